uart_rx_word_fifo: RTL and testbench

Receive-side buffer directly downstream of the UART receiver. Detects each completed byte from the receiver's `ready`/`rx_data` pair, pairs consecutive bytes into 16-bit little-endian words, and queues them in a small first-word-fall-through FIFO. The CPU/bus side reads whole words with a single-cycle pop strobe.

---
 rtl/uart_rx_word_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_rx_word_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word_fifo.sv
// rtl/uart_rx_word_fifo.sv - UART receive byte-pair to 16-bit word FIFO
//
// Purpose:
//   Watches the UART receiver's ready/rx_data pair and detects each completed
//   byte on the rising edge of ready. It pairs consecutive bytes into 16-bit
//   little-endian words: the first byte is the low byte. Each word goes into a
//   first-word-fall-through FIFO that the bus side pops one word per strobe.
//
// Ports:
//   clock_50M     in   1               system clock
//   n_rst         in   1               synchronous active-low reset
//   rx_ready      in   1               receiver ready (1 = idle, 0 = receiving)
//   rx_data       in   8               received byte, valid once rx_ready rises
//   rd_en         in   1               pop strobe, one word per cycle high
//   clear_ovf     in   1               clears overflow
//   rd_data       out  16              head word, 16'h0000 when empty
//   empty         out  1               FIFO holds no words
//   full          out  1               FIFO holds 2^DEPTH_LOG2 words
//   count         out  DEPTH_LOG2+1    number of words stored
//   half_pending  out  1               low byte held, waiting for high byte
//   overflow      out  1               sticky: a completed word was dropped

module uart_rx_word_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock_50M,
  input  logic                  n_rst,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rd_en,
  input  logic                  clear_ovf,
  output logic [15:0]           rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  half_pending,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  rx_ready_d;
  logic                  byte_stb;
  logic [7:0]            lo_buf;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [15:0]           mem [DEPTH];

  // rx_ready_d resets high so the idle-high ready seen after reset is not
  // mistaken for a freshly completed byte.
  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      rx_ready_d <= 1'b1;
    end else begin
      rx_ready_d <= rx_ready;
    end
  end

  assign byte_stb = rx_ready & ~rx_ready_d;

  // Assembly FSM: state register
  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      state_q <= ST_LOW;
    end else begin
      state_q <= state_d;
    end
  end

  // Assembly FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOW:  if (byte_stb) state_d = ST_HIGH;
      ST_HIGH: if (byte_stb) state_d = ST_LOW;
      default: state_d = ST_LOW;
    endcase
  end

  // Assembly FSM: outputs
  always_comb begin
    half_pending = 1'b0;
    push_req     = 1'b0;
    case (state_q)
      ST_LOW:  half_pending = 1'b0;
      ST_HIGH: begin
        half_pending = 1'b1;
        push_req     = byte_stb;
      end
      default: half_pending = 1'b0;
    endcase
  end

  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      lo_buf <= 8'h00;
    end else if (byte_stb && (state_q == ST_LOW)) begin
      lo_buf <= rx_data;
    end
  end

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign pop   = rd_en & ~empty;

  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // still accepts the word.
  assign push_ok = push_req & (~full | pop);

  // Storage is not reset; empty masks any stale contents.
  always_ff @(posedge clock_50M) begin
    if (push_ok) begin
      mem[wr_ptr] <= {rx_data, lo_buf};
    end
  end

  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A rejected push outranks a clear in the same cycle.
  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      overflow <= 1'b0;
    end else if (push_req && !push_ok) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign rd_data = empty ? 16'h0000 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// tb/tb_uart_rx_word_fifo.sv - directed bench for uart_rx_word_fifo

module tb_uart_rx_word_fifo;

  logic        clock_50M;
  logic        n_rst;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rd_en;
  logic        clear_ovf;
  logic [15:0] rd_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        half_pending;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  uart_rx_word_fifo #(.DEPTH_LOG2(3)) dut (
    .clock_50M    (clock_50M),
    .n_rst        (n_rst),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rd_en        (rd_en),
    .clear_ovf    (clear_ovf),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .half_pending (half_pending),
    .overflow     (overflow)
  );

  initial clock_50M = 1'b0;
  always #5 clock_50M = ~clock_50M;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // All tasks start and end at a falling edge; inputs change and outputs are
  // sampled there, half a cycle away from the active edge.
  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b0;
    rx_data  = b;
    @(negedge clock_50M);
    rx_ready = 1'b1;
    @(negedge clock_50M);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic pop_expect(input logic [15:0] exp, input string name);
    checks++;
    if (rd_data !== exp) begin
      errors++;
      $display("FAIL %s: rd_data got %h expected %h", name, rd_data, exp);
    end
    rd_en = 1'b1;
    @(negedge clock_50M);
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    rx_ready = 1'b1;
    rx_data = 8'h5A;
    rd_en = 1'b0;
    clear_ovf = 1'b0;
    repeat (3) @(negedge clock_50M);
    n_rst = 1'b1;
    repeat (20) @(negedge clock_50M);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if (half_pending !== 1'b0) begin errors++; $display("FAIL reset_half: got %b expected 0", half_pending); end
    checks++;
    if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    checks++;
    if (full !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_full_ovf: got %b%b expected 00", full, overflow);
    end
  endtask

  task automatic test_single_word;
    send_byte(8'h34);
    checks++;
    if (half_pending !== 1'b1) begin errors++; $display("FAIL single_half: got %b expected 1", half_pending); end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL single_count0: got %0d expected 0", count); end
    send_byte(8'h12);
    checks++;
    if (rd_data !== 16'h1234) begin errors++; $display("FAIL single_data: got %h expected 1234", rd_data); end
    checks++;
    if (count !== 4'd1 || half_pending !== 1'b0) begin
      errors++; $display("FAIL single_count1: got %0d/%b expected 1/0", count, half_pending);
    end
    pop_expect(16'h1234, "single_pop");
    checks++;
    if (empty !== 1'b1 || rd_data !== 16'h0000) begin
      errors++; $display("FAIL single_after_pop: got %b/%h expected 1/0000", empty, rd_data);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 8; i++) send_word(16'h0100 + 16'(i));
    checks++;
    if (full !== 1'b1 || count !== 4'd8) begin
      errors++; $display("FAIL ovf_full: got %b/%0d expected 1/8", full, count);
    end
    send_word(16'h0199);
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      errors++; $display("FAIL ovf_drop: got %b/%0d expected 1/8", overflow, count);
    end
    for (int i = 0; i < 8; i++) pop_expect(16'h0100 + 16'(i), "ovf_pop");
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b/%b expected 1/1", empty, overflow);
    end
    clear_ovf = 1'b1;
    @(negedge clock_50M);
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_push_pop_full;
    for (int i = 0; i < 8; i++) send_word(16'h0200 + 16'(i));
    send_byte(8'h08);
    rx_ready = 1'b0;
    rx_data  = 8'h02;
    @(negedge clock_50M);
    rx_ready = 1'b1;
    rd_en    = 1'b1;
    @(negedge clock_50M);
    rd_en    = 1'b0;
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      errors++; $display("FAIL pp_count: got %0d/%b expected 8/0", count, overflow);
    end
    for (int i = 1; i < 9; i++) pop_expect(16'h0200 + 16'(i), "pp_pop");
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL pp_empty: got %b expected 1", empty); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 20; i++) begin
      send_word(16'h0300 + 16'(i));
      if (i >= 2) pop_expect(16'h0300 + 16'(i - 2), "wrap_pop");
    end
    checks++;
    if (count !== 4'd2) begin errors++; $display("FAIL wrap_outstanding: got %0d expected 2", count); end
    // consecutive-cycle pops
    checks++;
    if (rd_data !== 16'h0312) begin errors++; $display("FAIL wrap_b2b0: got %h expected 0312", rd_data); end
    rd_en = 1'b1;
    @(negedge clock_50M);
    checks++;
    if (rd_data !== 16'h0313) begin errors++; $display("FAIL wrap_b2b1: got %h expected 0313", rd_data); end
    @(negedge clock_50M);
    rd_en = 1'b0;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL wrap_end: got %0d/%b expected 0/1", count, empty);
    end
  endtask

  task automatic test_reset_mid_word;
    send_byte(8'hEE);
    checks++;
    if (half_pending !== 1'b1) begin errors++; $display("FAIL mid_half: got %b expected 1", half_pending); end
    n_rst = 1'b0;
    @(negedge clock_50M);
    n_rst = 1'b1;
    checks++;
    if (half_pending !== 1'b0) begin errors++; $display("FAIL mid_cleared: got %b expected 0", half_pending); end
    send_byte(8'hCD);
    send_byte(8'hAB);
    checks++;
    if (rd_data !== 16'hABCD || count !== 4'd1) begin
      errors++; $display("FAIL mid_word: got %h/%0d expected abcd/1", rd_data, count);
    end
    pop_expect(16'hABCD, "mid_pop");
    rd_en = 1'b1;
    @(negedge clock_50M);
    rd_en = 1'b0;
    @(negedge clock_50M);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || rd_data !== 16'h0000) begin
      errors++; $display("FAIL mid_empty_pop: got %0d/%b/%h expected 0/1/0000", count, empty, rd_data);
    end
  endtask

  initial begin
    @(negedge clock_50M);
    test_reset;
    test_single_word;
    test_overflow;
    test_push_pop_full;
    test_back_to_back;
    test_reset_mid_word;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
